// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the sequential restoring divider:
//   - default operand width, carry flag width, TRUE/FALSE constants
//   - divider FSM state encoding (DIV_IDLE, DIV_CALC, DIV_DONE)
// No ports.
// ---------------------------------------------------------------------------
package div_seq_pkg;

    localparam int DIV_WORD_W = 16;
    localparam int CARRY_W    = 1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_seq_step.sv
// ---------------------------------------------------------------------------
// div_seq_step
// One combinational restoring-division step.
// Ports:
//   rem_in   in  WORD_W  partial remainder before the step (always < divisor)
//   bit_in   in  1       next dividend bit shifted into the remainder
//   divisor  in  WORD_W  divisor (nonzero)
//   rem_out  out WORD_W  partial remainder after the step
//   q_bit    out 1       quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_seq_step
    import div_seq_pkg::*;
#(
    parameter int WORD_W = DIV_WORD_W
) (
    input  logic [WORD_W-1:0] rem_in,
    input  logic              bit_in,
    input  logic [WORD_W-1:0] divisor,
    output logic [WORD_W-1:0] rem_out,
    output logic              q_bit
);

    logic [WORD_W:0] shifted;
    logic [WORD_W:0] trial;

    always_comb begin
        shifted = {rem_in, bit_in};
        // rem_in < divisor keeps shifted below 2*divisor, so the extra bit
        // is a reliable sign for the trial subtraction.
        trial   = shifted - {1'b0, divisor};
        if (trial[WORD_W] == FALSE) begin
            rem_out = trial[WORD_W-1:0];
            q_bit   = TRUE;
        end else begin
            rem_out = shifted[WORD_W-1:0];
            q_bit   = FALSE;
        end
    end

endmodule : div_seq_step

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Sequential restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (adds IN_SIGNED and two's complement
// division with truncation toward zero; remainder takes the dividend's sign).
// Ports:
//   CLK        in  1       clock, rising edge
//   RST_N      in  1       asynchronous active-low reset
//   IN_VALID   in  1       operand pair valid
//   IN_READY   out 1       high only in IDLE
//   IN_A       in  WORD_W  dividend
//   IN_B       in  WORD_W  divisor
//   IN_SIGNED  in  1       signed select (only with DIV_SIGNED_EN)
//   OUT_VALID  out 1       result valid (DONE state)
//   OUT_READY  in  1       consumer takes the result
//   OUT        out WORD_W  quotient (all ones for a zero divisor)
//   REM        out WORD_W  remainder (dividend for a zero divisor)
//   OUT_C      out 1       remainder nonzero, zero divisor, or signed overflow
// ---------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WORD_W = DIV_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WORD_W-1:0] IN_A,
    input  logic [WORD_W-1:0] IN_B,
`ifdef DIV_SIGNED_EN
    input  logic              IN_SIGNED,
`endif
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WORD_W-1:0] OUT,
    output logic [WORD_W-1:0] REM,
    output logic              OUT_C
);

    function automatic logic [WORD_W-1:0] neg_word(input logic [WORD_W-1:0] v);
        return (~v) + WORD_W'(1);
    endfunction

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] dvd_q, dvd_d;      // dividend, shifts out MSB-first, quotient fills LSBs
    logic [WORD_W-1:0] dvs_q, dvs_d;
    logic [WORD_W-1:0] prem_q, prem_d;    // partial remainder
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [WORD_W-1:0] rem_q, rem_d;
    logic              out_c_q, out_c_d;

    // Operand conditioning at the accept edge
    logic              a_neg, b_neg, ovf_in;
    logic [WORD_W-1:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
    logic signed [WORD_W-1:0] a_s, b_s;

    always_comb begin
        a_s    = IN_A;
        b_s    = IN_B;
        a_neg  = IN_SIGNED & (a_s < 0);
        b_neg  = IN_SIGNED & (b_s < 0);
        a_mag  = a_neg ? neg_word(IN_A) : IN_A;
        b_mag  = b_neg ? neg_word(IN_B) : IN_B;
        // most-negative / -1 cannot be represented; the natural result of the
        // magnitude path is already most-negative with zero remainder.
        ovf_in = IN_SIGNED & (IN_A == {1'b1, {(WORD_W-1){1'b0}}}) & (IN_B == '1);
    end
`else
    always_comb begin
        a_neg  = FALSE;
        b_neg  = FALSE;
        a_mag  = IN_A;
        b_mag  = IN_B;
        ovf_in = FALSE;
    end
`endif

    logic [WORD_W-1:0] step_rem;
    logic              step_q;
    logic [WORD_W-1:0] quo_next;

    div_seq_step #(.WORD_W(WORD_W)) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[WORD_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign quo_next = {dvd_q[WORD_W-2:0], step_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        rem_d   = rem_q;
        out_c_d = out_c_q;

        case (state_q)
            DIV_IDLE: begin
                if (IN_VALID) begin
                    if (IN_B == '0) begin
                        out_d   = '1;
                        rem_d   = IN_A;
                        out_c_d = TRUE;
                        state_d = DIV_DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        prem_d  = '0;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        ovf_d   = ovf_in;
                        cnt_d   = CNT_W'(WORD_W - 1);
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                dvd_d  = quo_next;
                prem_d = step_rem;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    out_d   = q_neg_q ? neg_word(quo_next) : quo_next;
                    rem_d   = r_neg_q ? neg_word(step_rem) : step_rem;
                    out_c_d = (step_rem != '0) | ovf_q;
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (OUT_READY) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            q_neg_q <= FALSE;
            r_neg_q <= FALSE;
            ovf_q   <= FALSE;
            out_q   <= '0;
            rem_q   <= '0;
            out_c_q <= FALSE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            out_c_q <= out_c_d;
        end
    end

    assign IN_READY  = (state_q == DIV_IDLE);
    assign OUT_VALID = (state_q == DIV_DONE);
    assign OUT       = out_q;
    assign REM       = rem_q;
    assign OUT_C     = out_c_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
// Directed, table-driven bench for div_seq with WORD_W=16. Signed vectors are
// included when DIV_SIGNED_EN is defined. Latency is counted in clock edges
// after the accept edge until OUT_VALID is seen high.
// ---------------------------------------------------------------------------
module tb_div_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
`ifdef DIV_SIGNED_EN
    logic         in_signed;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic [W-1:0] rem;
    logic         out_c;

    div_seq #(.WORD_W(W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_A      (in_a),
        .IN_B      (in_b),
`ifdef DIV_SIGNED_EN
        .IN_SIGNED (in_signed),
`endif
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT       (out_q),
        .REM       (rem),
        .OUT_C     (out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         c;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
`ifdef DIV_SIGNED_EN
        in_signed = s;
`else
        if (s) $display("note: signed vector skipped in unsigned build");
`endif
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_wait_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        // Operands must have been captured; scribble over them.
        in_valid = 1'b0;
        in_a     = 16'hA5A5;
        in_b     = 16'h5A5A;
    endtask

    task automatic wait_result(input string name, output int lat);
        bit rdy_bad;
        lat     = 0;
        rdy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_timeout"}, {31'd0, ~out_valid}, 32'd0);
        chk({name, "_ready_low_busy"}, {31'd0, rdy_bad | in_ready}, 32'd0);
    endtask

    task automatic release_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] hq, hr;
        logic         hc;

        vecs.push_back('{16'd100,   16'd7,      1'b0, 16'd14,   16'd2,  1'b1, 16});
        vecs.push_back('{16'hFFFF,  16'h0001,   1'b0, 16'hFFFF, 16'd0,  1'b0, 16});
        vecs.push_back('{16'h0005,  16'h0009,   1'b0, 16'd0,    16'd5,  1'b1, 16});
        vecs.push_back('{16'd5,     16'd0,      1'b0, 16'hFFFF, 16'd5,  1'b1, 0});
        vecs.push_back('{16'd1000,  16'd3,      1'b0, 16'd333,  16'd1,  1'b1, 16});
        vecs.push_back('{16'd0,     16'd5,      1'b0, 16'd0,    16'd0,  1'b0, 16});
        vecs.push_back('{16'hFFFF,  16'hFFFF,   1'b0, 16'd1,    16'd0,  1'b0, 16});
        vecs.push_back('{16'h8000,  16'h0100,   1'b0, 16'h0080, 16'd0,  1'b0, 16});
        vecs.push_back('{16'd12345, 16'd100,    1'b0, 16'd123,  16'd45, 1'b1, 16});
        vecs.push_back('{16'hFFF9,  16'h0002,   1'b0, 16'h7FFC, 16'd1,  1'b1, 16});
        vecs.push_back('{16'h0000,  16'h0000,   1'b0, 16'hFFFF, 16'd0,  1'b1, 0});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{16'hFFF9,  16'h0002,   1'b1, 16'hFFFD, 16'hFFFF, 1'b1, 16});
        vecs.push_back('{16'h8000,  16'hFFFF,   1'b1, 16'h8000, 16'd0,    1'b1, 16});
        vecs.push_back('{16'h0007,  16'hFFFE,   1'b1, 16'hFFFD, 16'd1,    1'b1, 16});
        vecs.push_back('{16'hFFF8,  16'hFFFE,   1'b1, 16'd4,    16'd0,    1'b0, 16});
        vecs.push_back('{16'hFFF9,  16'h0000,   1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 0});
        in_signed = 1'b0;
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out",       {16'd0, out_q},     32'd0);
        chk("rst_rem",       {16'd0, rem},       32'd0);
        chk("rst_out_c",     {31'd0, out_c},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_result($sformatf("v%0d", i), lat);
            chk($sformatf("v%0d_latency", i), lat,                  vecs[i].lat);
            chk($sformatf("v%0d_out", i),     {16'd0, out_q},       {16'd0, vecs[i].q});
            chk($sformatf("v%0d_rem", i),     {16'd0, rem},         {16'd0, vecs[i].r});
            chk($sformatf("v%0d_out_c", i),   {31'd0, out_c},       {31'd0, vecs[i].c});
            release_out($sformatf("v%0d", i));
        end

        // Backpressure: result holds for 5 cycles in DONE
        accept(16'd100, 16'd7, 1'b0);
        wait_result("bp", lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_ready", k), {31'd0, in_ready},  32'd0);
            chk($sformatf("bp%0d_out", k),   {16'd0, out_q},     32'd14);
            chk($sformatf("bp%0d_rem", k),   {16'd0, rem},       32'd2);
            chk($sformatf("bp%0d_c", k),     {31'd0, out_c},     32'd1);
        end
        release_out("bp");

        // OUT_READY high while idle must not disturb the next operation
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rdy_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset mid-operation aborts and clears outputs at once
        accept(16'd1000, 16'd3, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out",   {16'd0, out_q},     32'd0);
        chk("abort_rem",   {16'd0, rem},       32'd0);
        chk("abort_c",     {31'd0, out_c},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        accept(16'd1000, 16'd3, 1'b0);
        wait_result("after_abort", lat);
        hq = out_q;
        hr = rem;
        hc = out_c;
        chk("after_abort_lat", lat,          32'd16);
        chk("after_abort_out", {16'd0, hq},  32'd333);
        chk("after_abort_rem", {16'd0, hr},  32'd1);
        chk("after_abort_c",   {31'd0, hc},  32'd1);
        release_out("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_seq
